ysyx_23060077_icache: RTL and testbench
=======================================

Name: ysyx_23060077_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU and the memory-side burst read channel.
- Accepts one fetch request at a time (valid/ready).
- Returns a 32-bit instruction word on a hit; on a miss, refills a whole line with one burst.
- Supports whole-cache invalidation for fence.i.

Parameters:
- ADDR_WIDTH, 32: width of the fetch and memory addresses.
- DATA_WIDTH, 32: width of an instruction word and of one memory beat.
- LINE_WORDS, 4: words per cache line (16-byte line); power of two.
- LINE_NUM, 16: number of lines; power of two.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifu_valid_i  in  1  fetch request valid.
- ifu_addr_i  in  ADDR_WIDTH  fetch address, word aligned.
- ifu_ready_o  out  1  one-cycle pulse: ifu_data_o holds the requested word.
- ifu_data_o  out  DATA_WIDTH  instruction word.
- ifu_fence_i  in  1  fence.i indication; a rising edge invalidates the cache.
- Icache_r_valid_o  out  1  burst read request to memory.
- Icache_r_addr_o  out  ADDR_WIDTH  line-aligned burst start address.
- Icache_r_ready_i  in  1  one read beat is present on Icache_r_data_i this cycle.
- Icache_r_data_i  in  DATA_WIDTH  read beat data.
- Icache_r_len_o  out  8  burst length minus one; constant LINE_WORDS-1 (= 3).
- Icache_r_last_i  in  1  final beat of the burst; only meaningful together with Icache_r_ready_i.

Behaviour:
- Address split: offset = addr[3:2], index = addr[7:4], tag = addr[31:8] (derived from the parameters).
- Storage per line: a valid bit, a tag, and LINE_WORDS data words.
- Reset (reset==0, async), all taking effect immediately:
  - state = IDLE, all valid bits = 0.
  - ifu_ready_o = 0, ifu_data_o = 0, Icache_r_valid_o = 0, Icache_r_addr_o = 0.
  - Beat counter = 0, fence edge register = 0.
- State IDLE:
  - When ifu_valid_i==1, latch ifu_addr_i into req_addr and go to LOOKUP.
  - ifu_valid_i is not sampled in any other state; requests are not pipelined.
- State LOOKUP: hit = valid[index] && tag match on req_addr.
  - Hit: ifu_ready_o = 1 combinationally for this cycle; ifu_data_o = line word[offset]; go to IDLE.
  - Hit latency: ready in the cycle after the request is accepted.
  - Miss: go to MISS; clear the beat counter.
- State MISS:
  - Icache_r_valid_o = 1 and Icache_r_addr_o = {req tag, req index, 4'b0}, both held stable for the whole burst.
  - Each cycle with Icache_r_ready_i==1: write Icache_r_data_i into word[beat counter] of the line at the request index, then increment the counter.
  - Beat with Icache_r_ready_i && Icache_r_last_i: write the beat, set the line valid, store the tag, go to LOOKUP (which then hits).
  - Icache_r_valid_o drops in the cycle after the last beat.
  - Cycles with Icache_r_ready_i==0 are stalls: nothing is written.
- ifu_data_o outside a ready pulse holds the last returned word (register updated on each ready pulse).
- ifu_ready_o is never high for two consecutive cycles.
- Eviction: on a miss, the indexed line is overwritten unconditionally (direct-mapped, no dirty state).
- fence.i:
  - A registered copy of ifu_fence_i detects the 0->1 edge; the edge clears all valid bits at that clock edge.
  - A level held high does not re-invalidate, so the fetch after fence.i can refill and hit.
  - If the edge occurs during MISS: the valid bits are cleared, the burst in progress still completes, and its line is marked valid (it was fetched after the fence).
  - If the edge occurs in the same cycle as a last beat: the refilled line ends valid and all other lines end invalid.
- Reset mid-refill: the burst is abandoned and all state returns to reset values. The memory side must tolerate the dropped request.
- No write path; data words are never modified except by refill.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request 0x3000_0004.
  - Memory response: 4 beats 0x11,0x22,0x33,0x44, last on beat 4.
  - Required: Icache_r_valid_o=1 with addr 0x3000_0000 and len 3; ifu_ready_o pulses once, one cycle after the last beat, with data 0x22.
- Hit:
  - Stimulus: next request 0x3000_000C.
  - Required: ifu_ready_o one cycle after acceptance, data 0x44, Icache_r_valid_o stays 0.
- Conflict eviction:
  - Stimulus: request 0x3000_0100 (same index, new tag), refill with 0xA0..0xA3; then request 0x3000_0000 again.
  - Required: data 0xA0 for the first request; the second request causes a new burst at 0x3000_0000.
- Beat stalls:
  - Stimulus: insert 2 idle cycles (Icache_r_ready_i=0) between beats.
  - Required: words still land in order; ready fires only after the beat with last.
- fence.i:
  - Stimulus: fill a line; pulse ifu_fence_i high for 5 cycles; re-request the same address.
  - Required: exactly one new burst, then a hit on the following request while the fence is still high.
- Reset during MISS:
  - Stimulus: assert reset after 2 beats.
  - Required: Icache_r_valid_o=0 and ifu_ready_o=0 immediately; the next request to that address misses.

Source files
------------

// File: rtl/ysyx_23060077_icache.sv
// Direct-mapped, read-only instruction cache between the IFU and a burst read port.
// One fetch in flight at a time; a miss refills the whole line, fence.i invalidates everything.
module ysyx_23060077_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINE_NUM   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_data_o,
  input  logic                  ifu_fence_i,
  output logic                  Icache_r_valid_o,
  output logic [ADDR_WIDTH-1:0] Icache_r_addr_o,
  input  logic                  Icache_r_ready_i,
  input  logic [DATA_WIDTH-1:0] Icache_r_data_i,
  output logic [7:0]            Icache_r_len_o,
  input  logic                  Icache_r_last_i
);

  localparam int BYTE_BITS   = $clog2(DATA_WIDTH / 8);
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam int INDEX_BITS  = $clog2(LINE_NUM);
  localparam int LINE_BITS   = BYTE_BITS + OFFSET_BITS;
  localparam int TAG_BITS    = ADDR_WIDTH - LINE_BITS - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [LINE_NUM-1:0]     valid;
  logic [TAG_BITS-1:0]     tag_arr  [LINE_NUM];
  logic [DATA_WIDTH-1:0]   data_arr [LINE_NUM][LINE_WORDS];
  logic [OFFSET_BITS-1:0]  beat_cnt;
  logic                    fence_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic [OFFSET_BITS-1:0]  req_offset;
  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]     req_tag;
  logic                    hit;
  logic                    fence_edge;
  logic                    beat;
  logic                    last_beat;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic                    unused_byte_bits;

  assign req_offset       = req_addr[LINE_BITS-1:BYTE_BITS];
  assign req_index        = req_addr[LINE_BITS+INDEX_BITS-1:LINE_BITS];
  assign req_tag          = req_addr[ADDR_WIDTH-1:LINE_BITS+INDEX_BITS];
  assign unused_byte_bits = ^req_addr[BYTE_BITS-1:0];

  assign hit        = valid[req_index] && (tag_arr[req_index] == req_tag);
  assign hit_word   = data_arr[req_index][req_offset];
  assign fence_edge = ifu_fence_i && !fence_q;
  assign beat       = (state == MISS) && Icache_r_ready_i;
  assign last_beat  = beat && Icache_r_last_i;

  always_comb begin
    state_next       = state;
    ifu_ready_o      = 1'b0;
    Icache_r_valid_o = 1'b0;
    Icache_r_addr_o  = '0;
    case (state)
      IDLE: begin
        if (ifu_valid_i) state_next = LOOKUP;
      end
      LOOKUP: begin
        ifu_ready_o = hit;
        state_next  = hit ? IDLE : MISS;
      end
      MISS: begin
        Icache_r_valid_o = 1'b1;
        Icache_r_addr_o  = {req_tag, req_index, {LINE_BITS{1'b0}}};
        if (last_beat) state_next = LOOKUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // The data output shows the array word during the ready pulse and holds it afterwards.
  assign ifu_data_o     = ifu_ready_o ? hit_word : data_q;
  assign Icache_r_len_o = 8'(LINE_WORDS - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_addr <= '0;
      valid    <= '0;
      beat_cnt <= '0;
      fence_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state   <= state_next;
      fence_q <= ifu_fence_i;
      if (state == IDLE && ifu_valid_i) req_addr <= ifu_addr_i;
      if (ifu_ready_o) data_q <= hit_word;
      if (state == LOOKUP && !hit) beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 1'b1;
      // A line refilled in the fence cycle was fetched after the fence, so it survives.
      if (fence_edge) valid <= '0;
      if (last_beat) valid[req_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (beat) data_arr[req_index][beat_cnt] <= Icache_r_data_i;
    if (last_beat) tag_arr[req_index] <= req_tag;
  end

endmodule

// File: tb/tb_ysyx_23060077_icache.sv
// Randomised self-checking bench for the icache against a line-residency model and a memory function.
module tb_ysyx_23060077_icache;

  logic        clock;
  logic        reset;
  logic        ifu_valid;
  logic [31:0] ifu_addr;
  logic        ifu_ready;
  logic [31:0] ifu_data;
  logic        ifu_fence;
  logic        r_valid;
  logic [31:0] r_addr;
  logic        r_ready;
  logic [31:0] r_data;
  logic [7:0]  r_len;
  logic        r_last;

  int checks;
  int errors;
  int unsigned mem_over [int unsigned];
  int unsigned resident [int];

  ysyx_23060077_icache dut (
    .clock            (clock),
    .reset            (reset),
    .ifu_valid_i      (ifu_valid),
    .ifu_addr_i       (ifu_addr),
    .ifu_ready_o      (ifu_ready),
    .ifu_data_o       (ifu_data),
    .ifu_fence_i      (ifu_fence),
    .Icache_r_valid_o (r_valid),
    .Icache_r_addr_o  (r_addr),
    .Icache_r_ready_i (r_ready),
    .Icache_r_data_i  (r_data),
    .Icache_r_len_o   (r_len),
    .Icache_r_last_i  (r_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Any 0->1 transition of fence.i empties the cache model.
  task automatic setFence(input logic v);
    if (v && !ifu_fence) resident.delete();
    ifu_fence = v;
  endtask

  // Issues one fetch at a negedge with the DUT idle, acts as memory, and returns idle.
  task automatic applyStimulus(input logic [31:0] addr, input int stall_min, input int stall_max,
                               input bit fence_mid);
    int          idx;
    int unsigned line;
    bit          exp_hit;
    bit          got_ready;
    bit          burst_seen;
    logic [31:0] got_data;
    int          cycles;
    int          beats;
    int          stall;
    int          last_cycle;
    idx        = int'((addr >> 4) & 32'hF);
    line       = addr >> 4;
    exp_hit    = resident.exists(idx) && resident[idx] == line;
    got_ready  = 1'b0;
    burst_seen = 1'b0;
    got_data   = '0;
    cycles     = 0;
    beats      = 0;
    last_cycle = -10;
    stall      = int'($urandom_range(stall_max, stall_min));
    ifu_valid  = 1'b1;
    ifu_addr   = addr;
    @(negedge clock);
    ifu_valid = 1'b0;
    ifu_addr  = $urandom;
    while (cycles < 300) begin
      cycles++;
      r_ready = 1'b0;
      r_last  = 1'b0;
      r_data  = $urandom;
      if (ifu_ready) begin
        got_ready = 1'b1;
        got_data  = ifu_data;
        break;
      end
      if (r_valid) begin
        if (!burst_seen) begin
          burst_seen = 1'b1;
          checkOutput($sformatf("burst_addr %h", addr), r_addr, {line[27:0], 4'b0});
          checkOutput("burst_len", {24'b0, r_len}, 32'd3);
        end
        if (stall > 0) stall--;
        else begin
          r_ready = 1'b1;
          r_data  = mem_word({line[27:0], 4'b0} + 32'(beats * 4));
          r_last  = (beats == 3);
          if (beats == 3) last_cycle = cycles;
          beats++;
          stall = int'($urandom_range(stall_max, stall_min));
          if (fence_mid && beats == 1) setFence(1'b1);
        end
      end
      @(negedge clock);
    end
    checkOutput($sformatf("ready_seen %h", addr), {31'b0, got_ready}, 32'd1);
    if (got_ready) begin
      checkOutput($sformatf("data %h", addr), got_data, mem_word(addr));
      checkOutput($sformatf("burst_taken %h", addr), {31'b0, burst_seen}, {31'b0, !exp_hit});
      if (exp_hit) checkOutput("hit_latency", cycles, 1);
      else begin
        checkOutput("miss_latency", cycles, last_cycle + 1);
        checkOutput("beat_count", beats, 4);
      end
      @(negedge clock);
      checkOutput("ready_single_pulse", {31'b0, ifu_ready}, 32'd0);
      checkOutput("data_hold", ifu_data, got_data);
    end
    resident[idx] = line;
  endtask

  initial begin
    logic [31:0] a;
    int          wait_cycles;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    ifu_valid = 1'b0;
    ifu_addr  = '0;
    ifu_fence = 1'b0;
    r_ready   = 1'b0;
    r_data    = '0;
    r_last    = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_over[32'h3000_0000 + 32'(i * 4)] = 32'h11 * (i + 1);
      mem_over[32'h3000_0100 + 32'(i * 4)] = 32'hA0 + 32'(i);
    end
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_ready", {31'b0, ifu_ready}, 32'd0);
    checkOutput("reset_data", ifu_data, 32'd0);
    checkOutput("reset_r_valid", {31'b0, r_valid}, 32'd0);
    checkOutput("reset_r_addr", r_addr, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    applyStimulus(32'h3000_0004, 0, 0, 1'b0);
    checkOutput("cold_miss_word", ifu_data, 32'h22);
    applyStimulus(32'h3000_000C, 0, 0, 1'b0);
    checkOutput("hit_word", ifu_data, 32'h44);
    applyStimulus(32'h3000_0100, 0, 0, 1'b0);
    checkOutput("evict_word", ifu_data, 32'hA0);
    applyStimulus(32'h3000_0000, 0, 0, 1'b0);
    checkOutput("refill_word", ifu_data, 32'h11);
    applyStimulus(32'h3000_0204, 2, 2, 1'b0);
    applyStimulus(32'h3000_0208, 0, 0, 1'b0);

    setFence(1'b1);
    @(negedge clock);
    applyStimulus(32'h3000_0208, 0, 0, 1'b0);
    applyStimulus(32'h3000_0208, 0, 0, 1'b0);
    setFence(1'b0);
    @(negedge clock);
    applyStimulus(32'h3000_0300, 0, 1, 1'b1);
    applyStimulus(32'h3000_0304, 0, 0, 1'b0);
    applyStimulus(32'h3000_0000, 0, 0, 1'b0);
    setFence(1'b0);
    @(negedge clock);

    ifu_valid = 1'b1;
    ifu_addr  = 32'h3000_0404;
    @(negedge clock);
    ifu_valid   = 1'b0;
    wait_cycles = 0;
    while (!r_valid && wait_cycles < 20) begin
      @(negedge clock);
      wait_cycles++;
    end
    checkOutput("rst_burst_start", {31'b0, r_valid}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      r_ready = 1'b1;
      r_data  = mem_word(32'h3000_0400 + 32'(b * 4));
      @(negedge clock);
    end
    r_ready = 1'b0;
    reset   = 1'b0;
    #1;
    checkOutput("rst_mid_r_valid", {31'b0, r_valid}, 32'd0);
    checkOutput("rst_mid_ready", {31'b0, ifu_ready}, 32'd0);
    checkOutput("rst_mid_data", ifu_data, 32'd0);
    resident.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(32'h3000_0404, 0, 0, 1'b0);
    applyStimulus(32'h3000_0400, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = 32'h3000_0000 | (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(15, 0)) << 4)
          | (32'($urandom_range(3, 0)) << 2);
      if ($urandom_range(9, 0) == 0) setFence(1'($urandom_range(1, 0)));
      applyStimulus(a, 0, 3, $urandom_range(19, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
